knn_topk_select: RTL and testbench
==================================

Name: knn_topk_select

Overview:
- Downstream stage of the k-NN distance stream.
- Consumes one query's stream of (distance, train-label) candidates and keeps the k smallest distances in a sorted parallel compare-shift register array.
- After the query's last candidate, emits the k neighbours in ascending distance order on a valid/ready stream for the label-vote stage.
- k is taken from the register-map k-value field.

Parameters:
- DIST_W, 32, candidate distance width, unsigned.
- LABEL_W, 8, train-label width.
- K_MAX, 16, number of physical slots in the sorted array.
- K_W, $clog2(K_MAX+1), width of the k-value and count fields.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- k_val  in  K_W  neighbours wanted, from the register map.
- s_valid  in  1  candidate valid.
- s_ready  out  1  candidate accepted when s_valid & s_ready.
- s_dist  in  DIST_W  candidate distance.
- s_label  in  LABEL_W  candidate label.
- s_last  in  1  final candidate of the current query.
- m_valid  out  1  neighbour output valid.
- m_ready  in  1  downstream ready.
- m_dist  out  DIST_W  neighbour distance.
- m_label  out  LABEL_W  neighbour label.
- m_last  out  1  final neighbour of the query.
- busy  out  1  query in progress: at least 1 candidate accepted, or draining.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: state=COLLECT; all slot valid bits 0; count=0; k_eff=0; m_valid=0; m_dist=0; m_label=0; m_last=0; busy=0. s_ready=0 while rst is high and 1 from the first clk edge after release.
- Reset mid-query or mid-drain discards all stored entries. No partial output is produced.
- States:
  - COLLECT: s_ready=1, m_valid=0.
  - DRAIN: s_ready=0, m_valid=1.
- k latch:
  - On the first accepted beat of a query, k_eff = clamp(k_val): 0 becomes 1, values above K_MAX become K_MAX.
  - k_val changes are ignored for the rest of that query.
- Insertion (COLLECT, one candidate per cycle, no stalls):
  - An empty slot compares as +infinity.
  - The candidate goes to the lowest slot i < k_eff where s_dist < slot[i].dist (strict).
  - Slots i..k_eff-2 shift up by one; the entry in slot k_eff-1 is dropped.
  - Ties: an earlier-arrived candidate stays ahead. A candidate equal to slot[k_eff-1] with the array full is discarded.
  - count = min(count+1, k_eff).
  - A single-beat query (first beat with s_last=1) is valid.
- Transition to DRAIN:
  - On the clk edge that accepts s_last, the insertion is applied and state goes to DRAIN.
  - m_valid is high on the next cycle (latency 1 from the s_last handshake).
- DRAIN:
  - m_dist/m_label always present slot[0]; m_last = (count==1).
  - On each m_valid & m_ready, the array shifts down one slot and count decrements.
  - Outputs are held stable while m_ready is low.
  - If the query had fewer candidates than k_eff, only count neighbours are emitted.
  - After the handshake with m_last=1: state goes to COLLECT, all valid bits clear, busy drops, and s_ready=1 on the following cycle.
- Arithmetic: unsigned compare only, no distance arithmetic. Distance 2^DIST_W-1 is a legal value and still beats an empty slot.

Optional Feature:
- Macro: KNN_TOPK_STATS_EN.
- Defined:
  - Adds output ports cand_cnt [31:0] and ins_cnt [31:0].
  - cand_cnt counts candidates accepted in the current query; ins_cnt counts candidates that were inserted.
  - Both clear to 0 on reset and on the first beat of a new query, saturate at 2^32-1, and hold their values through DRAIN for the register map to read.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- k_val=3; candidates dist 50,10,40,20,30 with labels 1..5, last on the 5th -> outputs (10,2),(20,4),(30,5); m_last on 3rd; m_valid exactly 1 cycle after the last handshake.
- k_val=4; 2 candidates (7,L9),(3,L8) -> outputs (3,8),(7,9); m_last on 2nd; then s_ready=1.
- k_val=2; dists 5,5,5 with labels A,B,C -> outputs (5,A),(5,B); C discarded (tie rule).
- k_val=0, then k_val=20 in two separate queries -> k_eff=1 and k_eff=K_MAX=16 respectively. k_val changed to 1 mid-query (from 3) -> 3 outputs still emitted.
- During DRAIN with m_ready toggling 1010 -> outputs stable while stalled, no duplicates or drops. Assert rst mid-DRAIN -> m_valid=0 immediately; the next query after release is unaffected by old data.
- With KNN_TOPK_STATS_EN defined: k=2, 6 candidates in descending distance -> cand_cnt=6, ins_cnt=6. Same 6 candidates in ascending distance -> ins_cnt=2.

Source files
------------

// File: rtl/knn_topk_select.sv
// Top-k selector for the k-NN distance stream: keeps the k smallest (distance, label) pairs
// in a sorted compare-shift array and drains them in ascending order. Optional macro KNN_TOPK_STATS_EN adds query counters.
module knn_topk_select #(
    parameter int DIST_W  = 32,
    parameter int LABEL_W = 8,
    parameter int K_MAX   = 16,
    parameter int K_W     = $clog2(K_MAX + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [K_W-1:0]     k_val,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [DIST_W-1:0]  s_dist,
    input  logic [LABEL_W-1:0] s_label,
    input  logic               s_last,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [DIST_W-1:0]  m_dist,
    output logic [LABEL_W-1:0] m_label,
    output logic               m_last,
`ifdef KNN_TOPK_STATS_EN
    output logic [31:0]        cand_cnt,
    output logic [31:0]        ins_cnt,
`endif
    output logic               busy
);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } state_t;

    function automatic logic [K_W-1:0] clamp_k(input logic [K_W-1:0] k);
        if (k == K_W'(0)) begin
            clamp_k = K_W'(1);
        end else if (k > K_W'(K_MAX)) begin
            clamp_k = K_W'(K_MAX);
        end else begin
            clamp_k = k;
        end
    endfunction

    state_t             state_r, state_next_s;
    logic [DIST_W-1:0]  slot_dist_r  [K_MAX];
    logic [LABEL_W-1:0] slot_label_r [K_MAX];
    logic [K_MAX-1:0]   slot_valid_r;
    logic [DIST_W-1:0]  dist_next_s  [K_MAX];
    logic [LABEL_W-1:0] label_next_s [K_MAX];
    logic [K_MAX-1:0]   valid_next_s;
    logic [DIST_W-1:0]  up_dist_s    [K_MAX];
    logic [LABEL_W-1:0] up_label_s   [K_MAX];
    logic [DIST_W-1:0]  dn_dist_s    [K_MAX];
    logic [LABEL_W-1:0] dn_label_s   [K_MAX];
    logic [K_MAX-1:0]   lt_s, prev_lt_s;
    logic [K_W-1:0]     count_r, count_next_s;
    logic [K_W-1:0]     k_eff_r, k_use_s;
    logic               s_ready_r, m_valid_r, busy_r;
    logic               accept_s, first_s, drain_hs_s, final_hs_s, busy_next_s;

    assign accept_s   = s_valid && s_ready_r && (state_r == COLLECT);
    assign first_s    = !busy_r;
    assign k_use_s    = first_s ? clamp_k(k_val) : k_eff_r;
    assign drain_hs_s = m_valid_r && m_ready;
    assign final_hs_s = drain_hs_s && (count_r == K_W'(1));

    assign s_ready = s_ready_r;
    assign m_valid = m_valid_r;
    assign m_dist  = slot_dist_r[0];
    assign m_label = slot_label_r[0];
    assign m_last  = m_valid_r && (count_r == K_W'(1));
    assign busy    = busy_r;

    // Per-slot compare: empty slots act as +infinity, slots at or above k_eff never take the candidate.
    always_comb begin
        lt_s      = '0;
        prev_lt_s = '0;
        for (int i = 0; i < K_MAX; i++) begin
            if (K_W'(i) < k_use_s) begin
                lt_s[i] = !slot_valid_r[i] || (s_dist < slot_dist_r[i]);
            end else begin
                lt_s[i] = 1'b0;
            end
        end
        for (int i = 1; i < K_MAX; i++) begin
            prev_lt_s[i] = lt_s[i-1];
        end
    end

    // Neighbour views of the array used for shift-up on insert and shift-down on drain.
    always_comb begin
        up_dist_s[0]          = '0;
        up_label_s[0]         = '0;
        dn_dist_s[K_MAX-1]    = '0;
        dn_label_s[K_MAX-1]   = '0;
        for (int i = 1; i < K_MAX; i++) begin
            up_dist_s[i]  = slot_dist_r[i-1];
            up_label_s[i] = slot_label_r[i-1];
        end
        for (int i = 0; i < K_MAX - 1; i++) begin
            dn_dist_s[i]  = slot_dist_r[i+1];
            dn_label_s[i] = slot_label_r[i+1];
        end
    end

    // Next array contents and occupancy count.
    always_comb begin
        dist_next_s  = slot_dist_r;
        label_next_s = slot_label_r;
        valid_next_s = slot_valid_r;
        count_next_s = count_r;
        if (accept_s) begin
            // The first slot whose compare fires takes the candidate; slots above it take their lower neighbour.
            for (int i = 0; i < K_MAX; i++) begin
                if (lt_s[i] && prev_lt_s[i]) begin
                    dist_next_s[i]  = up_dist_s[i];
                    label_next_s[i] = up_label_s[i];
                    valid_next_s[i] = (i == 0) ? 1'b1 : slot_valid_r[i-1];
                end else if (lt_s[i]) begin
                    dist_next_s[i]  = s_dist;
                    label_next_s[i] = s_label;
                    valid_next_s[i] = 1'b1;
                end else begin
                    dist_next_s[i]  = slot_dist_r[i];
                    label_next_s[i] = slot_label_r[i];
                    valid_next_s[i] = slot_valid_r[i];
                end
            end
            if (first_s) begin
                count_next_s = K_W'(1);
            end else if (count_r >= k_use_s) begin
                count_next_s = k_use_s;
            end else begin
                count_next_s = count_r + K_W'(1);
            end
        end else if (final_hs_s) begin
            valid_next_s = '0;
            count_next_s = '0;
        end else if (drain_hs_s) begin
            dist_next_s  = dn_dist_s;
            label_next_s = dn_label_s;
            valid_next_s = {1'b0, slot_valid_r[K_MAX-1:1]};
            count_next_s = count_r - K_W'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Next-state and busy decode.
    always_comb begin
        state_next_s = state_r;
        busy_next_s  = busy_r;
        case (state_r)
            COLLECT: begin
                if (accept_s && s_last) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = COLLECT;
                end
                busy_next_s = busy_r || accept_s;
            end
            DRAIN: begin
                if (final_hs_s) begin
                    state_next_s = COLLECT;
                    busy_next_s  = 1'b0;
                end else begin
                    state_next_s = DRAIN;
                    busy_next_s  = 1'b1;
                end
            end
            default: begin
                state_next_s = COLLECT;
                busy_next_s  = 1'b0;
            end
        endcase
    end

    // Control state, handshake outputs and latched k.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= COLLECT;
            s_ready_r <= 1'b0;
            m_valid_r <= 1'b0;
            busy_r    <= 1'b0;
            count_r   <= '0;
            k_eff_r   <= '0;
        end else begin
            state_r   <= state_next_s;
            s_ready_r <= (state_next_s == COLLECT);
            m_valid_r <= (state_next_s == DRAIN);
            busy_r    <= busy_next_s;
            count_r   <= count_next_s;
            if (accept_s && first_s) begin
                k_eff_r <= k_use_s;
            end
        end
    end

    // Sorted slot storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < K_MAX; i++) begin
                slot_dist_r[i]  <= '0;
                slot_label_r[i] <= '0;
            end
            slot_valid_r <= '0;
        end else begin
            slot_dist_r  <= dist_next_s;
            slot_label_r <= label_next_s;
            slot_valid_r <= valid_next_s;
        end
    end

`ifdef KNN_TOPK_STATS_EN
    logic [31:0] cand_cnt_r, ins_cnt_r;
    logic        ins_s;

    assign ins_s    = |lt_s;
    assign cand_cnt = cand_cnt_r;
    assign ins_cnt  = ins_cnt_r;

    // Per-query saturating counters; restart on the first beat so DRAIN still shows the finished query.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand_cnt_r <= 32'd0;
            ins_cnt_r  <= 32'd0;
        end else if (accept_s && first_s) begin
            cand_cnt_r <= 32'd1;
            ins_cnt_r  <= ins_s ? 32'd1 : 32'd0;
        end else if (accept_s) begin
            cand_cnt_r <= (cand_cnt_r == 32'hFFFF_FFFF) ? cand_cnt_r : cand_cnt_r + 32'd1;
            if (ins_s && (ins_cnt_r != 32'hFFFF_FFFF)) begin
                ins_cnt_r <= ins_cnt_r + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_knn_topk_select.sv
// Directed bench for knn_topk_select: sorting, ties, k clamping, stalls, reset mid-drain, optional stats.
module tb_knn_topk_select;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  k_val;
    logic        s_valid, s_ready, s_last;
    logic [31:0] s_dist;
    logic [7:0]  s_label;
    logic        m_valid, m_ready, m_last;
    logic [31:0] m_dist;
    logic [7:0]  m_label;
    logic        busy;
`ifdef KNN_TOPK_STATS_EN
    logic [31:0] cand_cnt, ins_cnt;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    knn_topk_select dut (
        .clk(clk), .rst(rst), .k_val(k_val),
        .s_valid(s_valid), .s_ready(s_ready), .s_dist(s_dist), .s_label(s_label), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_dist(m_dist), .m_label(m_label), .m_last(m_last),
`ifdef KNN_TOPK_STATS_EN
        .cand_cnt(cand_cnt), .ins_cnt(ins_cnt),
`endif
        .busy(busy)
    );

    // Called #1 after an edge; presents one beat and returns #1 after the edge that takes it.
    task automatic send_beat(input logic [31:0] d, input logic [7:0] l, input logic last);
        vec_cnt++;
        if (s_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL send_ready: s_ready=%b required 1 (dist %0d)", s_ready, d);
        end
        s_valid = 1'b1; s_dist = d; s_label = l; s_last = last;
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; k_val = 5'd0; s_valid = 1'b0; s_dist = '0; s_label = '0; s_last = 1'b0; m_ready = 1'b0;
        #2;
        vec_cnt++;
        if ({s_ready, m_valid, m_dist, m_label, m_last, busy} !== 44'd0) begin
            err_cnt++;
            $display("FAIL reset_vals: got rdy=%b mv=%b d=%0d l=%0d ml=%b busy=%b required all 0",
                     s_ready, m_valid, m_dist, m_label, m_last, busy);
        end
        @(posedge clk); #1;
        vec_cnt++;
        if (s_ready !== 1'b0) begin err_cnt++; $display("FAIL reset_hold_ready: s_ready=%b required 0", s_ready); end
        rst = 1'b0;
        @(posedge clk); #1;
        vec_cnt++;
        if ({s_ready, m_valid, busy} !== 3'b100) begin
            err_cnt++;
            $display("FAIL reset_release: rdy/mv/busy=%b required 100", {s_ready, m_valid, busy});
        end
    endtask

    task automatic test_basic();
        logic [31:0] ed [3] = '{32'd10, 32'd20, 32'd30};
        logic [7:0]  el [3] = '{8'd2, 8'd4, 8'd5};
        k_val = 5'd3;
        send_beat(32'd50, 8'd1, 1'b0);
        vec_cnt++;
        if (busy !== 1'b1) begin err_cnt++; $display("FAIL basic_busy: busy=%b required 1", busy); end
        send_beat(32'd10, 8'd2, 1'b0);
        send_beat(32'd40, 8'd3, 1'b0);
        send_beat(32'd20, 8'd4, 1'b0);
        vec_cnt++;
        if (m_valid !== 1'b0) begin err_cnt++; $display("FAIL basic_early_valid: m_valid=%b required 0", m_valid); end
        send_beat(32'd30, 8'd5, 1'b1);
        m_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            vec_cnt++;
            if ({m_valid, m_dist, m_label, m_last} !== {1'b1, ed[j], el[j], (j == 2)}) begin
                err_cnt++;
                $display("FAIL basic_out%0d: got v=%b d=%0d l=%0d last=%b required v=1 d=%0d l=%0d last=%b",
                         j, m_valid, m_dist, m_label, m_last, ed[j], el[j], (j == 2));
            end
            @(posedge clk); #1;
        end
        vec_cnt++;
        if ({m_valid, s_ready, busy} !== 3'b010) begin
            err_cnt++;
            $display("FAIL basic_end: mv/rdy/busy=%b required 010", {m_valid, s_ready, busy});
        end
    endtask

    task automatic test_short_query();
        k_val = 5'd4;
        send_beat(32'd7, 8'd9, 1'b0);
        send_beat(32'd3, 8'd8, 1'b1);
        m_ready = 1'b1;
        vec_cnt++;
        if ({m_valid, m_dist, m_label, m_last} !== {1'b1, 32'd3, 8'd8, 1'b0}) begin
            err_cnt++;
            $display("FAIL short_out0: got v=%b d=%0d l=%0d last=%b required 1/3/8/0", m_valid, m_dist, m_label, m_last);
        end
        @(posedge clk); #1;
        vec_cnt++;
        if ({m_valid, m_dist, m_label, m_last} !== {1'b1, 32'd7, 8'd9, 1'b1}) begin
            err_cnt++;
            $display("FAIL short_out1: got v=%b d=%0d l=%0d last=%b required 1/7/9/1", m_valid, m_dist, m_label, m_last);
        end
        @(posedge clk); #1;
        vec_cnt++;
        if ({m_valid, s_ready} !== 2'b01) begin
            err_cnt++;
            $display("FAIL short_end: mv/rdy=%b required 01", {m_valid, s_ready});
        end
    endtask

    task automatic test_ties();
        k_val = 5'd2;
        send_beat(32'd5, 8'hA, 1'b0);
        send_beat(32'd5, 8'hB, 1'b0);
        send_beat(32'd5, 8'hC, 1'b1);
        m_ready = 1'b1;
        for (int j = 0; j < 2; j++) begin
            vec_cnt++;
            if ({m_valid, m_dist, m_label, m_last} !== {1'b1, 32'd5, 8'(8'hA + j), (j == 1)}) begin
                err_cnt++;
                $display("FAIL ties_out%0d: got v=%b d=%0d l=%h last=%b required v=1 d=5 l=%h last=%b",
                         j, m_valid, m_dist, m_label, m_last, 8'(8'hA + j), (j == 1));
            end
            @(posedge clk); #1;
        end
        vec_cnt++;
        if (m_valid !== 1'b0) begin err_cnt++; $display("FAIL ties_extra: m_valid=%b required 0", m_valid); end
    endtask

    task automatic test_k_clamp();
        // k_val=0 behaves as k=1
        k_val = 5'd0;
        send_beat(32'd30, 8'd1, 1'b0);
        send_beat(32'd10, 8'd2, 1'b0);
        send_beat(32'd20, 8'd3, 1'b1);
        m_ready = 1'b1;
        vec_cnt++;
        if ({m_valid, m_dist, m_label, m_last} !== {1'b1, 32'd10, 8'd2, 1'b1}) begin
            err_cnt++;
            $display("FAIL k0_out: got v=%b d=%0d l=%0d last=%b required 1/10/2/1", m_valid, m_dist, m_label, m_last);
        end
        @(posedge clk); #1;
        // k_val=20 clamps to 16; 17 descending candidates drop the largest
        k_val = 5'd20;
        for (int i = 0; i < 17; i++) send_beat(32'(100 - i), 8'(i), (i == 16));
        for (int j = 0; j < 16; j++) begin
            vec_cnt++;
            if ({m_valid, m_dist, m_label, m_last} !== {1'b1, 32'(84 + j), 8'(16 - j), (j == 15)}) begin
                err_cnt++;
                $display("FAIL k20_out%0d: got v=%b d=%0d l=%0d last=%b required v=1 d=%0d l=%0d last=%b",
                         j, m_valid, m_dist, m_label, m_last, 84 + j, 16 - j, (j == 15));
            end
            @(posedge clk); #1;
        end
        vec_cnt++;
        if (m_valid !== 1'b0) begin err_cnt++; $display("FAIL k20_extra: m_valid=%b required 0", m_valid); end
        // k changes mid-query are ignored
        k_val = 5'd3;
        send_beat(32'd4, 8'h40, 1'b0);
        k_val = 5'd1;
        send_beat(32'd3, 8'h30, 1'b0);
        send_beat(32'd2, 8'h20, 1'b0);
        send_beat(32'd1, 8'h10, 1'b1);
        for (int j = 0; j < 3; j++) begin
            vec_cnt++;
            if ({m_valid, m_dist, m_label, m_last} !== {1'b1, 32'(j + 1), 8'(8'h10 * (j + 1)), (j == 2)}) begin
                err_cnt++;
                $display("FAIL kchg_out%0d: got v=%b d=%0d l=%h last=%b required v=1 d=%0d l=%h last=%b",
                         j, m_valid, m_dist, m_label, m_last, j + 1, 8'(8'h10 * (j + 1)), (j == 2));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall();
        logic [31:0] ed [3] = '{32'd7, 32'd8, 32'd9};
        logic [7:0]  el [3] = '{8'd3, 8'd2, 8'd1};
        int idx = 0;
        k_val = 5'd3;
        send_beat(32'd9, 8'd1, 1'b0);
        send_beat(32'd8, 8'd2, 1'b0);
        send_beat(32'd7, 8'd3, 1'b1);
        for (int c = 0; c < 20 && idx < 3; c++) begin
            m_ready = (c % 2 == 0);
            vec_cnt++;
            if ({m_valid, m_dist, m_label, m_last} !== {1'b1, ed[idx], el[idx], (idx == 2)}) begin
                err_cnt++;
                $display("FAIL stall_c%0d: got v=%b d=%0d l=%0d last=%b required v=1 d=%0d l=%0d last=%b",
                         c, m_valid, m_dist, m_label, m_last, ed[idx], el[idx], (idx == 2));
            end
            @(posedge clk); #1;
            if (m_ready) idx++;
        end
        vec_cnt++;
        if (idx != 3 || m_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL stall_end: emitted %0d mv=%b required 3 and 0", idx, m_valid);
        end
        m_ready = 1'b1;
    endtask

    task automatic test_reset_mid_drain();
        k_val = 5'd3;
        send_beat(32'd100, 8'd1, 1'b0);
        send_beat(32'd200, 8'd2, 1'b1);
        m_ready = 1'b1;
        vec_cnt++;
        if ({m_valid, m_dist, m_label, m_last} !== {1'b1, 32'd100, 8'd1, 1'b0}) begin
            err_cnt++;
            $display("FAIL rstd_out0: got v=%b d=%0d l=%0d last=%b required 1/100/1/0", m_valid, m_dist, m_label, m_last);
        end
        @(posedge clk); #1;
        m_ready = 1'b0;
        rst = 1'b1;
        #1;
        vec_cnt++;
        if ({m_valid, m_last, busy, s_ready} !== 4'b0000) begin
            err_cnt++;
            $display("FAIL rstd_async: mv/ml/busy/rdy=%b required 0000", {m_valid, m_last, busy, s_ready});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        vec_cnt++;
        if ({s_ready, m_valid} !== 2'b10) begin
            err_cnt++;
            $display("FAIL rstd_release: rdy/mv=%b required 10", {s_ready, m_valid});
        end
        k_val = 5'd2;
        send_beat(32'd60, 8'd6, 1'b1);
        m_ready = 1'b1;
        vec_cnt++;
        if ({m_valid, m_dist, m_label, m_last} !== {1'b1, 32'd60, 8'd6, 1'b1}) begin
            err_cnt++;
            $display("FAIL rstd_fresh: got v=%b d=%0d l=%0d last=%b required 1/60/6/1", m_valid, m_dist, m_label, m_last);
        end
        @(posedge clk); #1;
        vec_cnt++;
        if (m_valid !== 1'b0) begin err_cnt++; $display("FAIL rstd_stale: m_valid=%b required 0", m_valid); end
    endtask

`ifdef KNN_TOPK_STATS_EN
    task automatic test_stats();
        for (int pass = 0; pass < 2; pass++) begin
            k_val = 5'd2;
            for (int i = 0; i < 6; i++) begin
                send_beat((pass == 0) ? 32'(60 - 10 * i) : 32'(10 + 10 * i), 8'(i), (i == 5));
            end
            vec_cnt++;
            if (cand_cnt !== 32'd6 || ins_cnt !== ((pass == 0) ? 32'd6 : 32'd2)) begin
                err_cnt++;
                $display("FAIL stats_p%0d: cand=%0d ins=%0d required 6 and %0d",
                         pass, cand_cnt, ins_cnt, (pass == 0) ? 6 : 2);
            end
            m_ready = 1'b1;
            @(posedge clk); #1;
            @(posedge clk); #1;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_short_query();
        test_ties();
        test_k_clamp();
        test_stall();
        test_reset_mid_drain();
`ifdef KNN_TOPK_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
